// File: rtl/complex_mac_issuer.sv
// Job sequencer for the complex multiply-add unit: issues operand packets under result-FIFO credit,
// collects in-order results and streams them to the sink. Optional watchdog: COMPLEX_MAC_ISSUER_TIMEOUT_EN.
module complex_mac_issuer #(
  parameter int LEN_W          = 16,
  parameter int RSP_FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [4:0]       status_acc_o,
  output logic             timeout_o,
  input  logic             src_valid_i,
  output logic             src_ready_o,
  input  logic [255:0]     src_data_i,
  output logic             req_valid_o,
  input  logic             req_ready_i,
  output logic [255:0]     req_operands_o,
  output logic             req_flush_o,
  input  logic             unit_busy_i,
  input  logic             rsp_valid_i,
  output logic             rsp_ready_o,
  input  logic [255:0]     rsp_result_i,
  input  logic [4:0]       rsp_status_i,
  output logic             dst_valid_o,
  input  logic             dst_ready_i,
  output logic [255:0]     dst_data_o,
  output logic             dst_last_o
);

  localparam int PTR_W = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    ABORT = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued;
  logic [LEN_W-1:0] received;
  logic [LEN_W-1:0] pop_cnt;
  logic [LEN_W-1:0] outstanding;
  logic [LEN_W:0]   credit_sum;
  logic [255:0]     fifo_mem [RSP_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   fifo_count;
  logic [4:0]       status_acc;
  logic             done_zero;
  logic             flush_q;
  logic             timeout_q;
  logic             active;
  logic             fifo_full;
  logic             fifo_empty;
  logic             credit_ok;
  logic             can_issue;
  logic             req_hs;
  logic             rsp_hs;
  logic             push;
  logic             pop;
  logic             final_pop;
  logic             abort_req;
  logic             wd_fire;
  logic             accept_start;
  logic             start_job;

  assign active       = (state == RUN) || (state == DRAIN);
  assign fifo_full    = (fifo_count == (PTR_W+1)'(RSP_FIFO_DEPTH));
  assign fifo_empty   = (fifo_count == '0);
  assign outstanding  = issued - received;
  assign credit_sum   = {1'b0, outstanding} + (LEN_W+1)'(fifo_count);
  assign credit_ok    = (credit_sum < (LEN_W+1)'(RSP_FIFO_DEPTH));
  assign can_issue    = (state == RUN) && credit_ok && (issued < len_q);
  assign accept_start = (state == IDLE) && start_i;
  assign start_job    = accept_start && (cfg_len_i != '0);
  assign abort_req    = active && (abort_i || wd_fire);

  // Request port is a pure pass-through of the source stream, gated by credit and job length.
  assign req_valid_o    = src_valid_i && can_issue;
  assign src_ready_o    = req_ready_i && can_issue;
  assign req_operands_o = (state == RUN) ? src_data_i : 256'd0;
  assign req_hs         = req_valid_o && req_ready_i;

  assign rsp_ready_o = (state == ABORT) || (active && !fifo_full);
  assign rsp_hs      = rsp_valid_i && rsp_ready_o;
  assign push        = rsp_hs && active;

  assign dst_valid_o = active && !fifo_empty;
  assign dst_data_o  = dst_valid_o ? fifo_mem[rd_ptr] : 256'd0;
  assign dst_last_o  = dst_valid_o && (pop_cnt == len_q - LEN_W'(1));
  assign pop         = dst_valid_o && dst_ready_i;
  assign final_pop   = pop && dst_last_o;

  assign busy_o       = (state != IDLE);
  assign done_o       = done_zero || (final_pop && !abort_req);
  assign req_flush_o  = flush_q;
  assign status_acc_o = status_acc;
  assign timeout_o    = timeout_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_job) state_next = RUN;
        else           state_next = IDLE;
      end
      RUN: begin
        if (abort_req)                                      state_next = ABORT;
        else if (req_hs && (issued + LEN_W'(1) == len_q))   state_next = DRAIN;
        else                                                state_next = RUN;
      end
      DRAIN: begin
        if (abort_req)      state_next = ABORT;
        else if (final_pop) state_next = IDLE;
        else                state_next = DRAIN;
      end
      // Hold until the flush pulse has gone out and the unit reports idle.
      ABORT: begin
        if (!unit_busy_i && !flush_q) state_next = IDLE;
        else                          state_next = ABORT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_q    <= '0;
      issued   <= '0;
      received <= '0;
      pop_cnt  <= '0;
    end else if (start_job) begin
      len_q    <= cfg_len_i;
      issued   <= '0;
      received <= '0;
      pop_cnt  <= '0;
    end else if (abort_req) begin
      issued   <= '0;
      received <= '0;
      pop_cnt  <= '0;
    end else begin
      if (req_hs) issued   <= issued + LEN_W'(1);
      if (push)   received <= received + LEN_W'(1);
      if (pop)    pop_cnt  <= pop_cnt + LEN_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (abort_req) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage array is never read while empty, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= rsp_result_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      status_acc <= 5'd0;
      done_zero  <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      done_zero <= accept_start && (cfg_len_i == '0);
      flush_q   <= abort_req;
      if (start_job)  status_acc <= 5'd0;
      else if (push)  status_acc <= status_acc | rsp_status_i;
    end
  end

`ifdef COMPLEX_MAC_ISSUER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_fire = active && (outstanding != '0) && !rsp_hs && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!active || rsp_hs || (outstanding == '0)) wd_cnt <= '0;
      else                                          wd_cnt <= wd_cnt + WD_W'(1);
      if (accept_start) timeout_q <= 1'b0;
      else if (wd_fire) timeout_q <= 1'b1;
    end
  end
`else
  // Watchdog not built; the expression is constant false for any legal limit.
  assign wd_fire   = (TIMEOUT_CYCLES < 0);
  assign timeout_q = 1'b0;
`endif

endmodule

// File: tb/tb_complex_mac_issuer.sv
// Randomized bench for complex_mac_issuer: a stub in-order unit plus a queue-based reference of the
// expected result stream, credit bound, done/last timing, status accumulation, abort and reset.
module tb_complex_mac_issuer;
  localparam int LEN_W  = 16;
  localparam int DEPTH  = 4;
  localparam int TO_CYC = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i, abort_i, src_valid_i, req_ready_i, unit_busy_i;
  logic             rsp_valid_i, dst_ready_i;
  logic [LEN_W-1:0] cfg_len_i;
  logic [255:0]     src_data_i, rsp_result_i;
  logic [4:0]       rsp_status_i;
  logic             busy_o, done_o, timeout_o, src_ready_o, req_valid_o, req_flush_o;
  logic             rsp_ready_o, dst_valid_o, dst_last_o;
  logic [4:0]       status_acc_o;
  logic [255:0]     req_operands_o, dst_data_o;

  always #5 clk = ~clk;

  complex_mac_issuer #(.LEN_W(LEN_W), .RSP_FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .cfg_len_i(cfg_len_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .status_acc_o(status_acc_o), .timeout_o(timeout_o),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o), .src_data_i(src_data_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_operands_o(req_operands_o),
    .req_flush_o(req_flush_o), .unit_busy_i(unit_busy_i), .rsp_valid_i(rsp_valid_i),
    .rsp_ready_o(rsp_ready_o), .rsp_result_i(rsp_result_i), .rsp_status_i(rsp_status_i),
    .dst_valid_o(dst_valid_o), .dst_ready_i(dst_ready_i), .dst_data_o(dst_data_o),
    .dst_last_o(dst_last_o)
  );

  typedef struct {
    logic [255:0] res;
    logic [4:0]   st;
    int           due;
  } beat_t;

  beat_t        unit_q[$];
  logic [255:0] exp_q[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, issued = 0, popped = 0, len_m = 0, flushes = 0, busy_hold = 0;
  int p_src = 100, p_rdy = 100, p_dst = 100, lat_min = 1, lat_max = 1;
  int last_issue_cyc = 0, flush_cyc = 0;
  bit seq_data = 1'b0, seq_status = 1'b0, no_rsp = 1'b0, aborted = 1'b0, done_seen = 1'b0;
  logic [4:0] st_m = 5'd0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Stand-in arithmetic for the unit; any fixed function distinguishes results from operands.
  function automatic logic [255:0] unit_fn(input logic [255:0] x);
    return {x[127:0], ~x[255:128]};
  endfunction

  task automatic drive();
    src_valid_i = (int'($urandom_range(99)) < p_src);
    src_data_i  = seq_data ? 256'(issued + 1) : rnd256();
    req_ready_i = (int'($urandom_range(99)) < p_rdy);
    dst_ready_i = (int'($urandom_range(99)) < p_dst);
    if (!no_rsp && unit_q.size() > 0 && unit_q[0].due <= cyc) begin
      rsp_valid_i  = 1'b1;
      rsp_result_i = unit_q[0].res;
      rsp_status_i = unit_q[0].st;
    end else begin
      rsp_valid_i  = 1'b0;
      rsp_result_i = rnd256();
      rsp_status_i = 5'($urandom);
    end
    unit_busy_i = (unit_q.size() > 0) || (busy_hold > 0);
  endtask

  task automatic tick(input bit abort_now);
    beat_t b;
    logic [255:0] d;
    bit rq, rs, dh, fin;
    drive();
    abort_i = abort_now;
    @(negedge clk);
    rq = req_valid_o && req_ready_i;
    check("hs_match", 256'(src_valid_i && src_ready_o), 256'(rq));
    if (rq) begin
      check("req_operands", req_operands_o, src_data_i);
      b.res = unit_fn(src_data_i);
      b.st  = seq_status ? ((issued == 0) ? 5'b00001 : 5'b10000) : 5'(1 << $urandom_range(4));
      b.due = cyc + lat_min + int'($urandom_range(lat_max - lat_min));
      unit_q.push_back(b);
      exp_q.push_back(b.res);
      issued++;
      last_issue_cyc = cyc;
    end
    rs = rsp_valid_i && rsp_ready_o;
    if (rs) begin
      b = unit_q.pop_front();
      if (!aborted) st_m = st_m | b.st;
    end
    if (req_flush_o) begin
      unit_q.delete();
      exp_q.delete();
      flushes++;
      flush_cyc = cyc;
      aborted = 1'b1;
    end
    dh  = dst_valid_o && dst_ready_i;
    fin = 1'b0;
    if (dh) begin
      if (exp_q.size() == 0) begin
        check("dst_extra", 256'(dst_valid_o), 256'd0);
      end else begin
        d = exp_q.pop_front();
        check("dst_data", dst_data_o, d);
        check("dst_last", 256'(dst_last_o), 256'(popped == len_m - 1));
        popped++;
        fin = (popped == len_m) && !abort_now;
      end
    end
    check("done", 256'(done_o), 256'(fin));
    if (done_o) done_seen = 1'b1;
    check("credit", 256'((issued - popped) <= DEPTH), 256'd1);
    check("issue_bound", 256'(issued <= len_m), 256'd1);
    if (aborted && busy_o) begin
      check("abort_req_valid", 256'(req_valid_o), 256'd0);
      check("abort_src_ready", 256'(src_ready_o), 256'd0);
      check("abort_dst_valid", 256'(dst_valid_o), 256'd0);
      check("abort_rsp_ready", 256'(rsp_ready_o), 256'd1);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (busy_hold > 0) busy_hold--;
  endtask

  task automatic start_job(input int len);
    src_valid_i = 1'b0; req_ready_i = 1'b0; dst_ready_i = 1'b0; rsp_valid_i = 1'b0;
    abort_i = 1'b0; start_i = 1'b1; cfg_len_i = LEN_W'(len);
    unit_busy_i = (unit_q.size() > 0);
    @(posedge clk);
    #1;
    cyc++;
    start_i = 1'b0;
    len_m = len; issued = 0; popped = 0; st_m = 5'd0; flushes = 0;
    exp_q.delete();
    aborted = 1'b0; done_seen = 1'b0;
    check("start_busy", 256'(busy_o), 256'd1);
    check("status_clear", 256'(status_acc_o), 256'd0);
    check("timeout_clear", 256'(timeout_o), 256'd0);
  endtask

  task automatic finish_job(input int budget);
    int n = 0;
    while (!done_seen && n < budget) begin
      tick(1'b0);
      n++;
    end
    check("job_done", 256'(done_seen), 256'd1);
    check("beats", 256'(popped), 256'(len_m));
    check("status_acc", 256'(status_acc_o), 256'(st_m));
    check("idle_after_done", 256'(busy_o), 256'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy_o && n < budget) begin
      tick(1'b0);
      n++;
    end
    check("reach_idle", 256'(busy_o), 256'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; cfg_len_i = '0;
    src_valid_i = 1'b0; src_data_i = '0; req_ready_i = 1'b0; unit_busy_i = 1'b0;
    rsp_valid_i = 1'b0; rsp_result_i = '0; rsp_status_i = 5'd0; dst_ready_i = 1'b0;
    #1;
    check("rst_busy", 256'(busy_o), 256'd0);
    check("rst_done", 256'(done_o), 256'd0);
    check("rst_req_valid", 256'(req_valid_o), 256'd0);
    check("rst_rsp_ready", 256'(rsp_ready_o), 256'd0);
    check("rst_dst_valid", 256'(dst_valid_o), 256'd0);
    check("rst_flush", 256'(req_flush_o), 256'd0);
    check("rst_status", 256'(status_acc_o), 256'd0);
    check("rst_timeout", 256'(timeout_o), 256'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Short job, fixed latency 2, sequential operand data.
    seq_data = 1'b1; lat_min = 2; lat_max = 2;
    start_job(3);
    finish_job(60);
    check("t1_issued", 256'(issued), 256'd3);
    seq_data = 1'b0;

    // Sink stalled: credit must cap issue at the FIFO depth.
    lat_min = 1; lat_max = 1; p_dst = 0;
    start_job(8);
    repeat (20) tick(1'b0);
    check("t2_issued_capped", 256'(issued), 256'(DEPTH));
    check("t2_req_valid_low", 256'(req_valid_o), 256'd0);
    check("t2_src_ready_low", 256'(src_ready_o), 256'd0);
    p_dst = 100;
    finish_job(200);
    check("t2_issued_all", 256'(issued), 256'd8);

    // Zero-length job.
    start_i = 1'b1; cfg_len_i = '0; src_valid_i = 1'b1; req_ready_i = 1'b1;
    @(negedge clk);
    check("t3_done_early", 256'(done_o), 256'd0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    @(negedge clk);
    check("t3_done", 256'(done_o), 256'd1);
    check("t3_busy", 256'(busy_o), 256'd0);
    check("t3_req_valid", 256'(req_valid_o), 256'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t3_done_once", 256'(done_o), 256'd0);
    @(posedge clk);
    #1;

    // Abort after two issues with the unit reporting busy for 3 more cycles.
    lat_min = 3; lat_max = 3;
    start_job(6);
    n = 0;
    while (issued < 2 && n < 20) begin
      tick(1'b0);
      n++;
    end
    p_src = 0;
    tick(1'b1);
    aborted = 1'b1; issued = 0; popped = 0; exp_q.delete();
    busy_hold = 3; p_src = 100; n = 0;
    while (busy_o && n < 30) begin
      tick(1'b0);
      n++;
    end
    check("t4_flush_once", 256'(flushes), 256'd1);
    check("t4_abort_cycles", 256'(n), 256'd4);
    check("t4_idle", 256'(busy_o), 256'd0);
    check("t4_no_done", 256'(done_seen), 256'd0);

    // Asynchronous reset in the middle of a job.
    lat_min = 1; lat_max = 1; p_dst = 0;
    start_job(8);
    repeat (6) tick(1'b0);
    check("t4r_pre_valid", 256'(dst_valid_o), 256'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t4r_busy", 256'(busy_o), 256'd0);
    check("t4r_dst_valid", 256'(dst_valid_o), 256'd0);
    check("t4r_dst_data", dst_data_o, 256'd0);
    check("t4r_req_valid", 256'(req_valid_o), 256'd0);
    check("t4r_src_ready", 256'(src_ready_o), 256'd0);
    check("t4r_rsp_ready", 256'(rsp_ready_o), 256'd0);
    check("t4r_status", 256'(status_acc_o), 256'd0);
    unit_q.delete(); exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0; p_dst = 100;

    // Status accumulation: 00001 then 10000.
    seq_status = 1'b1;
    start_job(2);
    finish_job(60);
    check("t5_status", 256'(status_acc_o), 256'(5'b10001));
    seq_status = 1'b0;
    start_job(1);
    finish_job(60);

    // Unit never responds.
    no_rsp = 1'b1;
    start_job(1);
`ifdef COMPLEX_MAC_ISSUER_TIMEOUT_EN
    n = 0;
    while (flushes == 0 && n < 200) begin
      tick(1'b0);
      n++;
    end
    check("t6_timeout", 256'(timeout_o), 256'd1);
    check("t6_latency_ok", 256'((flush_cyc - last_issue_cyc) >= TO_CYC && (flush_cyc - last_issue_cyc) <= TO_CYC + 1), 256'd1);
    no_rsp = 1'b0;
    wait_idle(50);
    check("t6_timeout_sticky", 256'(timeout_o), 256'd1);
`else
    repeat (100) tick(1'b0);
    check("t6_no_timeout", 256'(timeout_o), 256'd0);
    check("t6_still_busy", 256'(busy_o), 256'd1);
    tick(1'b1);
    aborted = 1'b1;
    no_rsp = 1'b0;
    wait_idle(50);
    check("t6_flush_once", 256'(flushes), 256'd1);
`endif

    // Randomized jobs.
    for (int j = 0; j < 8; j++) begin
      p_src = int'($urandom_range(30, 100));
      p_rdy = int'($urandom_range(30, 100));
      p_dst = int'($urandom_range(20, 100));
      lat_min = 1;
      lat_max = int'($urandom_range(1, 5));
      start_job(int'($urandom_range(1, 20)));
      finish_job(3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
